// File: rtl/uart_rx_ctrl.sv
// UART receive controller: acknowledges receiver events, buffers bytes in a FWFT FIFO, keeps sticky status.
// Optional framing-error counter is compiled in with `define UART_RX_CTRL_ERRCNT_EN.
module uart_rx_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_avail,
  input  logic                       i_rx_err,
  output logic                       o_rx_ack,
  output logic [7:0]                 o_data,
  output logic                       o_valid,
  input  logic                       i_rd,
  input  logic                       i_flush,
  input  logic                       i_clr,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overrun,
  output logic                       o_frame_err,
  output logic [7:0]                 o_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t          r_state;
  logic            r_rx_ack;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overrun;
  logic            r_frame_err;

  logic w_event;
  logic w_push_req;
  logic w_err_evt;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Events are only taken in IDLE, so a level flag held high yields one action.
  assign w_event    = (r_state == IDLE) && (i_rx_avail || i_rx_err);
  assign w_push_req = w_event && i_rx_avail && !i_rx_err;
  assign w_err_evt  = w_event && i_rx_err;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a concurrent push.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = i_rd && (r_count != '0) && !i_flush;
  assign w_push = w_push_req && (!w_full || w_pop) && !i_flush;
  assign w_drop = w_push_req && w_full && !w_pop && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rx_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_rx_avail || i_rx_err) begin
            r_state  <= ACK;
            r_rx_ack <= 1'b1;
          end
        end
        ACK: begin
          if (!i_rx_avail && !i_rx_err) begin
            r_state  <= IDLE;
            r_rx_ack <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rx_ack <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: storage has no reset; o_data is masked while empty, so stale contents never leak out.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as i_clr wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)      r_overrun <= 1'b1;
      else if (i_clr)  r_overrun <= 1'b0;
      if (w_err_evt)   r_frame_err <= 1'b1;
      else if (i_clr)  r_frame_err <= 1'b0;
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (w_err_evt) begin
      if (i_clr)                   r_err_cnt <= 8'd1;
      else if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end else if (i_clr) begin
      r_err_cnt <= '0;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = 8'd0;
`endif

  assign o_rx_ack    = r_rx_ack;
  assign o_valid     = (r_count != '0);
  assign o_data      = o_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_count     = r_count;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=8).
module tb_uart_rx_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_avail;
  logic       i_rx_err;
  logic       o_rx_ack;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_rd;
  logic       i_flush;
  logic       i_clr;
  logic [3:0] o_count;
  logic       o_overrun;
  logic       o_frame_err;
  logic [7:0] o_err_cnt;

  int n_total = 0;
  int n_pass  = 0;

`ifdef UART_RX_CTRL_ERRCNT_EN
  localparam logic [7:0] EXP_ERRCNT3 = 8'd3;
`else
  localparam logic [7:0] EXP_ERRCNT3 = 8'd0;
`endif

  uart_rx_ctrl #(.DEPTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_avail (i_rx_avail),
    .i_rx_err   (i_rx_err),
    .o_rx_ack   (o_rx_ack),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_rd       (i_rd),
    .i_flush    (i_flush),
    .i_clr      (i_clr),
    .o_count    (o_count),
    .o_overrun  (o_overrun),
    .o_frame_err(o_frame_err),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = o_rx_ack;
    end
    check(tag, got, 1'b1);
  endtask

  // Full receiver handshake: flags held until one cycle after ack rises.
  task automatic rx_event(input logic [7:0] d, input logic err);
    i_rx_data  = d;
    i_rx_avail = !err;
    i_rx_err   = err;
    wait_ack("ack_rise");
    tick();
    i_rx_avail = 1'b0;
    i_rx_err   = 1'b0;
    tick();
    check("ack_fall", o_rx_ack, 1'b0);
  endtask

  task automatic pop();
    i_rd = 1'b1;
    tick();
    i_rd = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_rx_data = 8'h00; i_rx_avail = 1'b0; i_rx_err = 1'b0;
    i_rd = 1'b0; i_flush = 1'b0; i_clr = 1'b0;
    tick(); tick();
    check("rst_ack",   o_rx_ack, 1'b0);
    check("rst_count", o_count, 4'd0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data",  o_data, 8'h00);
    check("rst_ovr",   o_overrun, 1'b0);
    check("rst_ferr",  o_frame_err, 1'b0);
    check("rst_ecnt",  o_err_cnt, 8'd0);
    i_rst = 1'b0;
    tick();

    // Single byte: ack high for exactly two sampled cycles, one push.
    i_rx_data = 8'h55; i_rx_avail = 1'b1;
    tick();
    check("b55_ack1",  o_rx_ack, 1'b1);
    tick();
    check("b55_ack2",  o_rx_ack, 1'b1);
    i_rx_avail = 1'b0;
    tick();
    check("b55_ack3",  o_rx_ack, 1'b0);
    check("b55_data",  o_data, 8'h55);
    check("b55_count", o_count, 4'd1);
    check("b55_valid", o_valid, 1'b1);
    pop();
    check("b55_empty", o_count, 4'd0);
    check("b55_nvld",  o_valid, 1'b0);

    // Overflow: nine bytes into eight slots.
    for (int i = 1; i <= 8; i++) rx_event(8'(i), 1'b0);
    check("full_count", o_count, 4'd8);
    check("full_novr",  o_overrun, 1'b0);
    rx_event(8'h09, 1'b0);
    check("ovf_count", o_count, 4'd8);
    check("ovf_ovr",   o_overrun, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_rd", o_data, 32'(i));
      pop();
    end
    check("ovf_empty", o_valid, 1'b0);

    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    check("clr_ovr", o_overrun, 1'b0);

    // Full FIFO, push and pop on the same edge.
    for (int i = 0; i < 8; i++) rx_event(8'h10 + 8'(i), 1'b0);
    i_rx_data = 8'hA5; i_rx_avail = 1'b1; i_rd = 1'b1;
    tick();
    i_rd = 1'b0;
    check("fpp_count", o_count, 4'd8);
    check("fpp_ovr",   o_overrun, 1'b0);
    check("fpp_ack",   o_rx_ack, 1'b1);
    check("fpp_head",  o_data, 8'h11);
    i_rx_avail = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) begin
      check("fpp_rd", o_data, 32'(8'h10 + 8'(i)));
      pop();
    end
    check("fpp_tail", o_data, 8'hA5);
    pop();
    check("fpp_empty", o_count, 4'd0);

    // Flush with a concurrent push: discarded, no overrun, still acknowledged.
    rx_event(8'h21, 1'b0);
    rx_event(8'h22, 1'b0);
    i_rx_data = 8'h23; i_rx_avail = 1'b1; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fl_count", o_count, 4'd0);
    check("fl_valid", o_valid, 1'b0);
    check("fl_ovr",   o_overrun, 1'b0);
    check("fl_ack",   o_rx_ack, 1'b1);
    i_rx_avail = 1'b0;
    tick();
    check("fl_ackf",  o_rx_ack, 1'b0);

    // Push and pop while empty: the pop is ignored.
    i_rx_data = 8'h3C; i_rx_avail = 1'b1; i_rd = 1'b1;
    tick();
    i_rd = 1'b0;
    check("epp_count", o_count, 4'd1);
    check("epp_data",  o_data, 8'h3C);
    i_rx_avail = 1'b0;
    tick();
    pop();
    check("epp_empty", o_count, 4'd0);

    // Framing errors: no pushes, sticky flag, counter.
    rx_event(8'hEE, 1'b1);
    rx_event(8'hEE, 1'b1);
    rx_event(8'hEE, 1'b1);
    check("ferr_flag",  o_frame_err, 1'b1);
    check("ferr_cnt",   o_err_cnt, EXP_ERRCNT3);
    check("ferr_count", o_count, 4'd0);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    check("ferr_clrf", o_frame_err, 1'b0);
    check("ferr_clrc", o_err_cnt, 8'd0);

    // Reset in ACK with avail still high, then a fresh event after release.
    i_rx_data = 8'h77; i_rx_avail = 1'b1;
    wait_ack("rstack_rise");
    check("rstack_cnt0", o_count, 4'd1);
    i_rst = 1'b1;
    tick();
    check("rstack_ack",   o_rx_ack, 1'b0);
    check("rstack_count", o_count, 4'd0);
    check("rstack_valid", o_valid, 1'b0);
    check("rstack_data",  o_data, 8'h00);
    i_rst = 1'b0;
    tick();
    check("rstack_ack2",  o_rx_ack, 1'b1);
    check("rstack_cnt2",  o_count, 4'd1);
    check("rstack_dat2",  o_data, 8'h77);
    tick();
    i_rx_avail = 1'b0;
    tick();
    tick();
    check("rstack_ackf",  o_rx_ack, 1'b0);
    check("rstack_cnt3",  o_count, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, receive FIFO depth in bytes; power of two, at least 2.
REQ-002 Derived: AW = log2(DEPTH); pointers are AW bits wide and the count is AW+1 bits wide.
REQ-003 Port: i_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 Port: i_rst  in  1  synchronous, active-high reset.
REQ-005 Port: i_rx_data  in  8  byte from the UART receiver.
REQ-006 Port: i_rx_avail  in  1  receiver byte-available flag; level, held until acknowledged.
REQ-007 Port: i_rx_err  in  1  receiver framing-error flag; level, held until acknowledged.
REQ-008 Port: o_rx_ack  out  1  acknowledge to the receiver; clears i_rx_avail and i_rx_err.
REQ-009 Port: o_data  out  8  FIFO head byte; valid while o_valid=1.
REQ-010 Port: o_valid  out  1  FIFO not empty.
REQ-011 Port: i_rd  in  1  pop the FIFO head; ignored when o_valid=0.
REQ-012 Port: i_flush  in  1  empty the FIFO.
REQ-013 Port: i_clr  in  1  clear the sticky status.
REQ-014 Port: o_count  out  AW+1  number of bytes in the FIFO, 0..DEPTH.
REQ-015 Port: o_overrun  out  1  sticky; a byte was dropped because the FIFO was full.
REQ-016 Port: o_frame_err  out  1  sticky; the receiver reported a framing error.
REQ-017 Port: o_err_cnt  out  8  framing-error count (see Configuration).

Function
REQ-018 FSM states: IDLE, ACK.
REQ-019 IDLE, on (i_rx_avail | i_rx_err) = 1: take the event action, set o_rx_ack=1 on the next cycle, and go to ACK.
REQ-020 Event action, i_rx_avail=1 and i_rx_err=0: push i_rx_data if the FIFO is not full; if full, drop the byte and set o_overrun.
REQ-021 Event action, i_rx_err=1 (regardless of i_rx_avail): push nothing, set o_frame_err, and increment the error counter.
REQ-022 ACK: hold o_rx_ack=1 until i_rx_avail=0 and i_rx_err=0 are sampled together.
  - In that cycle, o_rx_ack returns to 0 on the next edge and the FSM returns to IDLE.
  - No new event is taken while in ACK.
REQ-023 Exactly one event action occurs per receiver event, however long the flags stay high.
REQ-024 The FIFO is first-word-fall-through: o_data shows the head with zero read latency.
  - o_valid = (o_count != 0).
REQ-025 Pop on i_rd & o_valid; the next head is visible on the following cycle.
REQ-026 Pointers wrap modulo DEPTH; o_count is updated on the same edge as each push or pop.
REQ-027 Simultaneous push and pop, FIFO non-empty: both take effect and o_count is unchanged.
  - This includes the full case: the push is accepted and no overrun is flagged.
REQ-028 Simultaneous push and pop, FIFO empty: the push takes effect, the pop is ignored, and o_count becomes 1.
REQ-029 i_flush: o_count becomes 0 and both pointers are equalized on the next edge.
  - A push in the same cycle is discarded without an overrun, but the receiver event is still acknowledged.
  - A pop in the same cycle is ignored.
REQ-030 i_clr clears o_overrun, o_frame_err and o_err_cnt; a set event in the same cycle wins.

Reset
REQ-031 While i_rst=1 at an edge, the following take these values on that edge:
  - FSM=IDLE, o_rx_ack=0, o_count=0, pointers=0, o_valid=0;
  - o_overrun=0, o_frame_err=0, o_err_cnt=0, o_data=0.
REQ-032 Reset mid-ACK drops o_rx_ack on that edge.
  - After reset, a receiver flag that is still high is treated as a new event.
REQ-033 i_rst takes priority over i_flush, i_clr, i_rd and all events.

Configuration
REQ-034 The macro UART_RX_CTRL_ERRCNT_EN, when defined, compiles in the framing-error counter.
  - 8 bits wide, incremented per REQ-021, saturating at 255, driven on o_err_cnt.
REQ-035 Without UART_RX_CTRL_ERRCNT_EN, o_err_cnt is the constant 0, no counter logic is built, and all other behaviour is unchanged.

Verification
REQ-036 Receiver presents 0x55, avail=1, and drops avail 1 cycle after ack rises -> one push, o_data=0x55, o_count=1, and ack high for exactly 2 cycles.
REQ-037 DEPTH=8, 9 bytes 0x01..0x09 with no reads -> o_count=8, o_overrun=1, and reads return 0x01..0x08.
REQ-038 FIFO full (8) with a push and i_rd in the same cycle -> o_count stays 8, o_overrun=0, and the tail holds the new byte.
REQ-039 Three err=1 events, then i_clr -> o_frame_err=1 and o_err_cnt=3 (0 without the macro); both are 0 after i_clr.
REQ-040 i_rst asserted while in ACK with avail still high -> ack=0 and all outputs 0 after the edge; after release, a new ack is raised and one push occurs.
